// File: rtl/detector_sequencer.sv
// Test sequencer for the one-hot sequence detector: clears it, streams a pattern
// into w LSB first, and logs the detector's z response bit by bit.
module detector_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             z,
  output logic             w,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] z_log
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   shift_q, shift_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] zlog_q, zlog_d;
  logic             det_clr_q, busy_q, done_q;
  logic             sample_en;
  logic [KW-1:0]    sample_idx;

  // The pattern is loaded one position up so bit 0 stays 0 during CLEAR, and zeros
  // shift in behind it, keeping w low outside SHIFT without any output gating.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    k_d        = k_q;
    count_d    = count_q;
    zlog_d     = zlog_q;
    sample_en  = 1'b0;
    sample_idx = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          shift_d = {pattern, 1'b0};
          k_d     = '0;
          count_d = '0;
          zlog_d  = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
        shift_d = shift_q >> 1;
      end
      S_SHIFT: begin
        shift_d = shift_q >> 1;
        k_d     = k_q + 1'b1;
        // z lags w by one cycle, so bit k reports on bit k-1.
        if (k_q != '0) begin
          sample_en  = 1'b1;
          sample_idx = k_q - 1'b1;
        end
        if (k_q == KW'(WIDTH - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        sample_en  = 1'b1;
        sample_idx = KW'(WIDTH - 1);
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (sample_en) begin
      zlog_d[sample_idx] = z;
      if (z && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      k_q       <= '0;
      count_q   <= '0;
      zlog_q    <= '0;
      det_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      count_q   <= count_d;
      zlog_q    <= zlog_d;
      det_clr_q <= (state_d == S_CLEAR);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign w           = shift_q[0];
  assign det_clr     = det_clr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = count_q;
  assign z_log       = zlog_q;

endmodule
